// File: rtl/seq_wide_adder_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package seq_wide_adder_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   // Ceiling log2; callers clamp the result to at least one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned v = 1;
      int unsigned r = 0;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/byte_add_slice.sv
// Combinational 8-bit add slice built from a full-adder ripple chain.
module byte_add_slice
   import seq_wide_adder_pkg::*;
(
   input  logic [BYTE_W-1:0] a_i,
   input  logic [BYTE_W-1:0] b_i,
   input  logic              cin_i,
   output logic [BYTE_W-1:0] sum_o,
   output logic              cout_o
);

   logic [BYTE_W:0] cy;

   assign cy[0] = cin_i;

   for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
      assign sum_o[i]  = a_i[i] ^ b_i[i] ^ cy[i];
      assign cy[i + 1] = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = cy[BYTE_W];

endmodule

// File: rtl/seq_wide_adder.sv
// Multi-cycle wide adder: one byte per clock through a single add slice.
// Signed overflow output is implemented only when SEQ_WIDE_ADDER_OVF_EN is defined.
module seq_wide_adder
   import seq_wide_adder_pkg::*;
#(
   parameter int unsigned NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [BYTE_W*NBYTES-1:0] a,
   input  logic [BYTE_W*NBYTES-1:0] b,
   input  logic                     c0,
   output logic                     busy,
   output logic                     done,
   output logic [BYTE_W*NBYTES-1:0] s,
   output logic                     c,
   output logic                     ovf
);

   localparam int unsigned W        = BYTE_W * NBYTES;
   localparam int unsigned IDX_W    = (clog2(NBYTES) > 0) ? clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_e             state_q;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       s_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic               busy_q;
   logic               done_q;
   logic               c_q;

   logic [BYTE_W-1:0]  a_byte;
   logic [BYTE_W-1:0]  b_byte;
   logic [BYTE_W-1:0]  sum_byte_d;
   logic               carry_d;

   // Steer the current operand byte pair into the slice.
   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int i = 0; i < int'(NBYTES); i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_byte = a_q[i*BYTE_W +: BYTE_W];
            b_byte = b_q[i*BYTE_W +: BYTE_W];
         end
      end
   end

   byte_add_slice u_slice (
      .a_i    (a_byte),
      .b_i    (b_byte),
      .cin_i  (carry_q),
      .sum_o  (sum_byte_d),
      .cout_o (carry_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= c0;
                  idx_q   <= '0;
                  s_q     <= '0;
                  c_q     <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < int'(NBYTES); i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     s_q[i*BYTE_W +: BYTE_W] <= sum_byte_d;
                  end
               end
               carry_q <= carry_d;
               // The index parks on the last byte instead of wrapping.
               if (idx_q == LAST_IDX) begin
                  c_q     <= carry_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign c    = c_q;

`ifdef SEQ_WIDE_ADDER_OVF_EN
   logic ovf_q;

   // Overflow judged from operand sign bits and the top sum byte on the last RUN edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && idx_q == LAST_IDX) begin
         ovf_q <= (a_q[W-1] == b_q[W-1]) && (sum_byte_d[BYTE_W-1] != a_q[W-1]);
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule
